// File: rtl/lsu_mem_master_pkg.sv
// Shared load/store definitions: funct3 access encodings, LSU state encoding
// and small helpers for access width and legality.
package lsu_mem_master_pkg;

  localparam logic [2:0] FUNCT3_LS_B  = 3'b000;
  localparam logic [2:0] FUNCT3_LS_H  = 3'b001;
  localparam logic [2:0] FUNCT3_LS_W  = 3'b010;
  localparam logic [2:0] FUNCT3_LS_BU = 3'b100;
  localparam logic [2:0] FUNCT3_LS_HU = 3'b101;

  // Each op of a split misaligned access moves a single unsigned byte.
  localparam logic [2:0] MISALIGNED_BYTE_SIZE = FUNCT3_LS_BU;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_ISSUE,
    LSU_WAIT,
    LSU_RESP,
    LSU_ERR
  } lsu_state_e;

  function automatic logic [2:0] ls_nbytes(input logic [2:0] size);
    case (size[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic ls_size_legal(input logic [2:0] size);
    case (size)
      FUNCT3_LS_B, FUNCT3_LS_H, FUNCT3_LS_W,
      FUNCT3_LS_BU, FUNCT3_LS_HU: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load data formatter: selects the addressed byte/halfword from a raw word
// and applies sign or zero extension for the access size.
module lsu_load_fmt
  import lsu_mem_master_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
    shifted = raw >> {offset, 3'b000};
    data    = '0;
    case (size)
      FUNCT3_LS_B:  data = {{24{shifted[7]}}, shifted[7:0]};
      FUNCT3_LS_BU: data = {24'b0, shifted[7:0]};
      FUNCT3_LS_H:  data = {{16{shifted[15]}}, shifted[15:0]};
      FUNCT3_LS_HU: data = {16'b0, shifted[15:0]};
      FUNCT3_LS_W:  data = raw;
      default:      data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Data-memory port initiator: one load/store at a time, misaligned H/W split
// into byte ops, loaded data assembled, extended and returned with a pulse.
module lsu_mem_master
  import lsu_mem_master_pkg::*;
#(
  parameter bit          SPLIT_MISALIGNED = 1'b1,
  parameter int unsigned MEM_WORDS        = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wd,
  output logic        resp_valid,
  output logic [31:0] resp_rd,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d, split_q, split_d;
  logic [31:0] addr_q, addr_d, wd_q, wd_d, asm_q, asm_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        mem_we_q, mem_we_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wd_q, mem_wd_d, resp_rd_q, resp_rd_d;
  logic [2:0]  mem_size_q, mem_size_d;

  logic [2:0]  req_nbytes, nbytes_m1;
  logic [32:0] req_last_byte;
  logic        req_misaligned, req_err;
  logic [1:0]  last_cnt, next_cnt;
  logic [31:0] rd_shift, wd_shift, asm_next, fmt_out;

  // Error and alignment classification of the request being offered.
  always_comb begin
    req_nbytes     = ls_nbytes(req_size);
    req_misaligned = (req_nbytes == 3'd2 && req_addr[0]) ||
                     (req_nbytes == 3'd4 && req_addr[1:0] != 2'b00);
    req_last_byte  = {1'b0, req_addr} + 33'(req_nbytes) - 33'd1;
    req_err        = !ls_size_legal(req_size) || (req_we && req_size[2]) ||
                     (req_last_byte >= ADDR_LIMIT) ||
                     (req_misaligned && !SPLIT_MISALIGNED);
  end

  // The RAM returns whole words; a split op picks its byte lane from the
  // address it issued, an aligned op keeps the word for the formatter.
  always_comb begin
    nbytes_m1 = ls_nbytes(size_q) - 3'd1;
    last_cnt  = split_q ? nbytes_m1[1:0] : 2'd0;
    next_cnt  = cnt_q + 2'd1;
    rd_shift  = mem_rd >> {mem_addr_q[1:0], 3'b000};
    wd_shift  = wd_q >> {next_cnt, 3'b000};
    asm_next  = mem_rd;
    if (split_q) begin
      asm_next = asm_q;
      asm_next[{cnt_q, 3'b000} +: 8] = rd_shift[7:0];
    end
  end

  lsu_load_fmt u_load_fmt (
    .raw    (asm_next),
    .size   (size_q),
    .offset (split_q ? 2'b00 : addr_q[1:0]),
    .data   (fmt_out)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wd_d         = wd_q;
    split_d      = split_q;
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_size_d   = mem_size_q;
    mem_wd_d     = mem_wd_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rd_d    = '0;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          size_d  = req_size;
          wd_d    = req_wd;
          split_d = req_misaligned;
          cnt_d   = 2'd0;
          asm_d   = '0;
          if (req_err) begin
            state_d      = LSU_ERR;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d    = LSU_ISSUE;
            mem_we_d   = req_we;
            mem_addr_d = req_addr;
            mem_size_d = req_misaligned ? MISALIGNED_BYTE_SIZE : req_size;
            mem_wd_d   = req_misaligned ? {24'b0, req_wd[7:0]} : req_wd;
          end
        end
      end
      LSU_ISSUE: state_d = LSU_WAIT;
      LSU_WAIT: begin
        asm_d = asm_next;
        if (cnt_q == last_cnt) begin
          state_d      = LSU_RESP;
          resp_valid_d = 1'b1;
          resp_rd_d    = we_q ? '0 : fmt_out;
        end else begin
          state_d    = LSU_ISSUE;
          cnt_d      = next_cnt;
          mem_we_d   = we_q;
          mem_addr_d = addr_q + 32'(next_cnt);
          mem_wd_d   = {24'b0, wd_shift[7:0]};
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples values from before the edge.
    if (!rstn) begin
      state_q      <= LSU_IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      size_q       <= FUNCT3_LS_W;
      wd_q         <= '0;
      split_q      <= 1'b0;
      cnt_q        <= '0;
      asm_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_size_q   <= FUNCT3_LS_W;
      mem_wd_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wd_q         <= wd_d;
      split_q      <= split_d;
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_size_q   <= mem_size_d;
      mem_wd_q     <= mem_wd_d;
      resp_valid_q <= resp_valid_d;
      resp_rd_q    <= resp_rd_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == LSU_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rd    = resp_rd_q;
  assign resp_err   = resp_err_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_size   = mem_size_q;
  assign mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: a splitting and a non-splitting instance, each on
// a word RAM, checked against a byte-addressed reference memory model.
module tb_lsu_mem_master;
  import lsu_mem_master_pkg::*;

  localparam int MEM_WORDS = 1024;
  localparam int MEM_BYTES = 4 * MEM_WORDS;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clr_ram;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [2:0]  req_size  [2];
  logic [31:0] req_wd    [2];
  logic        resp_valid[2];
  logic [31:0] resp_rd   [2];
  logic        resp_err  [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [2:0]  mem_size  [2];
  logic [31:0] mem_wd    [2];
  logic [31:0] mem_rd    [2];

  logic [31:0] ram  [2][MEM_WORDS];
  logic [7:0]  refm [2][MEM_BYTES];

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  lsu_mem_master #(.SPLIT_MISALIGNED(1'b1), .MEM_WORDS(MEM_WORDS)) u_dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_wd(req_wd[0]),
    .resp_valid(resp_valid[0]), .resp_rd(resp_rd[0]), .resp_err(resp_err[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_size(mem_size[0]),
    .mem_wd(mem_wd[0]), .mem_rd(mem_rd[0])
  );

  lsu_mem_master #(.SPLIT_MISALIGNED(1'b0), .MEM_WORDS(MEM_WORDS)) u_dut_nosplit (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_wd(req_wd[1]),
    .resp_valid(resp_valid[1]), .resp_rd(resp_rd[1]), .resp_err(resp_err[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_size(mem_size[1]),
    .mem_wd(mem_wd[1]), .mem_rd(mem_rd[1])
  );

  function automatic logic [31:0] ram_merge(input logic [31:0] old, input logic [1:0] off,
                                            input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] w;
    w = old;
    case (size[1:0])
      2'b00:   w[8*off +: 8]  = wd[7:0];
      2'b01:   w[8*off +: 16] = wd[15:0];
      default: w = wd;
    endcase
    return w;
  endfunction

  // Word-organised RAM: write on the strobe, read data one cycle after address.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    always @(posedge clk) begin
      if (clr_ram) begin
        for (int i = 0; i < MEM_WORDS; i++) ram[g][i] <= '0;
      end else if (mem_we[g]) begin
        ram[g][mem_addr[g][11:2]] <= ram_merge(ram[g][mem_addr[g][11:2]], mem_addr[g][1:0],
                                                mem_size[g], mem_wd[g]);
      end
      mem_rd[g] <= ram[g][mem_addr[g][11:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One request on instance inst; expectations come from the reference memory.
  task automatic do_req(input int inst, input logic we, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wd, output logic [31:0] rd_o);
    int          nb, exp_lat, exp_wr, lat, wr;
    bit          mis, err, got;
    longint      last;
    logic [31:0] exp_rd, exp_wd;
    nb   = (size[1:0] == 2'b00) ? 1 : (size[1:0] == 2'b01) ? 2 : 4;
    mis  = (nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00);
    last = longint'(addr) + longint'(nb) - 1;
    err  = (size == 3'b011 || size == 3'b110 || size == 3'b111) || (we && size[2]) ||
           (last >= longint'(MEM_BYTES)) || (mis && inst == 1);
    exp_lat = err ? 1 : (mis ? 2 * nb + 1 : 3);
    exp_wr  = (err || !we) ? 0 : (mis ? nb : 1);
    exp_rd  = '0;
    if (!err && !we) begin
      for (int i = 0; i < nb; i++) exp_rd |= 32'(refm[inst][int'(addr) + i]) << (8 * i);
      if (size == FUNCT3_LS_B && exp_rd[7])  exp_rd |= 32'hFFFFFF00;
      if (size == FUNCT3_LS_H && exp_rd[15]) exp_rd |= 32'hFFFF0000;
    end

    @(negedge clk);
    check("req_ready_idle", 32'(req_ready[inst]), 32'd1);
    check("resp_pulse_end", 32'(resp_valid[inst]), 32'd0);
    req_valid[inst] = 1'b1;
    req_we[inst]    = we;
    req_addr[inst]  = addr;
    req_size[inst]  = size;
    req_wd[inst]    = wd;
    @(posedge clk);
    lat  = 0;
    wr   = 0;
    got  = 1'b0;
    rd_o = 'x;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (c == 1) req_valid[inst] = 1'b0;
      if (mem_we[inst]) begin
        exp_wd = mis ? ((wd >> (8 * wr)) & 32'hFF) : wd;
        check("wr_cycle", 32'(c), 32'(2 * wr + 1));
        check("wr_addr", mem_addr[inst], addr + 32'(wr));
        check("wr_size", 32'(mem_size[inst]), 32'(mis ? FUNCT3_LS_BU : size));
        check("wr_data", mem_wd[inst], exp_wd);
        wr++;
      end
      if (resp_valid[inst]) begin
        got  = 1'b1;
        lat  = c;
        rd_o = resp_rd[inst];
        check("resp_err", 32'(resp_err[inst]), 32'(err));
        check("resp_rd", resp_rd[inst], exp_rd);
      end
    end
    check("resp_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("write_count", 32'(wr), 32'(exp_wr));
    if (!err && we)
      for (int i = 0; i < nb; i++) refm[inst][int'(addr) + i] = wd[8*i +: 8];
  endtask

  logic [2:0]  size_tab [10] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101,
                                 3'b010, 3'b001, 3'b010, 3'b011, 3'b111};
  logic [31:0] rd, addr, wd, exp_word;
  int          inst, r;

  initial begin
    rstn    = 1'b0;
    clr_ram = 1'b1;
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0;
      req_we[g]    = 1'b0;
      req_addr[g]  = '0;
      req_size[g]  = '0;
      req_wd[g]    = '0;
      for (int i = 0; i < MEM_BYTES; i++) refm[g][i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr_ram = 1'b0;
    for (int g = 0; g < 2; g++) begin
      check("rst_ready", 32'(req_ready[g]), 32'd1);
      check("rst_mem_we", 32'(mem_we[g]), 32'd0);
      check("rst_mem_addr", mem_addr[g], 32'd0);
      check("rst_mem_size", 32'(mem_size[g]), 32'(FUNCT3_LS_W));
      check("rst_mem_wd", mem_wd[g], 32'd0);
      check("rst_resp_valid", 32'(resp_valid[g]), 32'd0);
      check("rst_resp_rd", resp_rd[g], 32'd0);
      check("rst_resp_err", 32'(resp_err[g]), 32'd0);
    end
    rstn = 1'b1;

    // Directed cases on the splitting instance.
    do_req(0, 1'b1, 32'h0, FUNCT3_LS_W, 32'h8899AABB, rd);
    do_req(0, 1'b0, 32'h2, FUNCT3_LS_B, 32'h0, rd);
    check("plan_load_b", rd, 32'hFFFFFF99);
    do_req(0, 1'b0, 32'h2, FUNCT3_LS_BU, 32'h0, rd);
    check("plan_load_bu", rd, 32'h00000099);
    do_req(0, 1'b1, 32'h10, FUNCT3_LS_W, 32'hDEADBEEF, rd);
    do_req(0, 1'b0, 32'h10, FUNCT3_LS_W, 32'h0, rd);
    check("plan_load_w", rd, 32'hDEADBEEF);
    do_req(0, 1'b1, 32'h0, FUNCT3_LS_W, 32'h44332211, rd);
    do_req(0, 1'b1, 32'h4, FUNCT3_LS_W, 32'h88776655, rd);
    do_req(0, 1'b0, 32'h3, FUNCT3_LS_W, 32'h0, rd);
    check("plan_split_w", rd, 32'h77665544);
    do_req(0, 1'b0, 32'h1, FUNCT3_LS_H, 32'h0, rd);
    check("plan_split_h", rd, 32'h00003322);
    do_req(0, 1'b1, 32'h5, FUNCT3_LS_H, 32'h0000A5C3, rd);
    do_req(0, 1'b0, 32'h4, FUNCT3_LS_W, 32'h0, rd);
    check("plan_word1", rd, 32'h88A5C355);
    do_req(0, 1'b0, 32'(MEM_BYTES - 2), FUNCT3_LS_W, 32'h0, rd);
    do_req(0, 1'b0, 32'h8, 3'b011, 32'h0, rd);
    do_req(0, 1'b1, 32'h8, FUNCT3_LS_HU, 32'h1234, rd);
    do_req(0, 1'b1, 32'(MEM_BYTES - 1), FUNCT3_LS_B, 32'h5A, rd);
    do_req(0, 1'b0, 32'(MEM_BYTES - 4), FUNCT3_LS_W, 32'h0, rd);
    do_req(0, 1'b0, 32'hFFFFFFFE, FUNCT3_LS_H, 32'h0, rd);
    // Non-splitting instance: misaligned is an error, aligned works.
    do_req(1, 1'b1, 32'h0, FUNCT3_LS_W, 32'h44332211, rd);
    do_req(1, 1'b0, 32'h1, FUNCT3_LS_H, 32'h0, rd);
    do_req(1, 1'b0, 32'h2, FUNCT3_LS_H, 32'h0, rd);
    check("nosplit_h_aligned", rd, 32'h00004433);

    // Randomized traffic over a small low window and the top boundary.
    for (int n = 0; n < 240; n++) begin
      inst = (n % 4 == 3) ? 1 : 0;
      r    = int'($urandom_range(0, 9));
      if (r < 7)      addr = $urandom_range(0, 63);
      else if (r < 9) addr = $urandom_range(MEM_BYTES - 10, MEM_BYTES + 4);
      else            addr = 32'hFFFFFFF0 + $urandom_range(0, 15);
      do_req(inst, 1'($urandom_range(0, 1)), addr, size_tab[$urandom_range(0, 9)], $urandom, rd);
    end

    // Reset during WAIT of the third byte of a split store.
    wd = 32'hCAFEF00D;
    @(negedge clk);
    check("abort_ready", 32'(req_ready[0]), 32'd1);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'd9;
    req_size[0]  = FUNCT3_LS_W;
    req_wd[0]    = wd;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) req_valid[0] = 1'b0;
    end
    check("abort_third_op", mem_addr[0], 32'd11);
    rstn = 1'b0;
    #1;
    check("abort_mem_we", 32'(mem_we[0]), 32'd0);
    check("abort_mem_addr", mem_addr[0], 32'd0);
    check("abort_mem_size", 32'(mem_size[0]), 32'(FUNCT3_LS_W));
    check("abort_mem_wd", mem_wd[0], 32'd0);
    check("abort_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("abort_resp_rd", resp_rd[0], 32'd0);
    check("abort_resp_err", 32'(resp_err[0]), 32'd0);
    for (int i = 0; i < 3; i++) refm[0][9 + i] = wd[8*i +: 8];
    repeat (3) begin
      @(negedge clk);
      check("abort_no_resp", 32'(resp_valid[0]), 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    check("abort_ready_after", 32'(req_ready[0]), 32'd1);
    check("abort_no_resp_after", 32'(resp_valid[0]), 32'd0);
    do_req(0, 1'b0, 32'd8, FUNCT3_LS_W, 32'h0, rd);
    check("abort_bytes_kept", rd & 32'h00FFFF00, {8'h00, wd[15:0], 8'h00});

    // RAM contents against the reference byte memory.
    for (int g = 0; g < 2; g++) begin
      for (int w = 0; w < MEM_WORDS; w++) begin
        if (w < 20 || w == MEM_WORDS - 1) begin
          exp_word = {refm[g][4*w+3], refm[g][4*w+2], refm[g][4*w+1], refm[g][4*w]};
          check("ram_word", ram[g][w], exp_word);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
